pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 151 +++++++++++++++
 tb/tb_pc_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// Fetch-stage sequencer: drives the PC register, issues instruction fetches and
// buffers a fetched word across stalls. Optional counters: `define PC_SEQ_PERF_EN.
module pc_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        f_valid,
    output logic [31:0] f_instr,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        redir_valid_q, redir_valid_d;
    logic [29:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [29:0] npc_word;

    // Targets and PCs are word addresses; the byte-offset bits never reach npc.
    logic unused_low_bits;
    assign unused_low_bits = ^{br_target[1:0], pc[1:0]};

    assign imem_addr = pc;

    always_comb begin
        state_d  = state_q;
        ibuf_d   = ibuf_q;
        pc_en    = 1'b0;
        f_valid  = 1'b0;
        imem_req = 1'b0;
        f_instr  = 32'h0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (!stall) begin
                        f_valid = 1'b1;
                        f_instr = imem_rdata;
                        pc_en   = 1'b1;
                    end else begin
                        ibuf_d  = imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    f_valid = 1'b1;
                    f_instr = ibuf_q;
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // A redirect that cannot be applied this cycle is parked until the next PC load.
    always_comb begin
        redir_valid_d = redir_valid_q;
        redir_tgt_d   = redir_tgt_q;
        if (pc_en) begin
            redir_valid_d = 1'b0;
        end else if (br_taken) begin
            redir_valid_d = 1'b1;
            redir_tgt_d   = br_target[31:2];
        end
    end

    always_comb begin
        npc_word = pc[31:2] + 30'd1;
        if (state_q == BOOT) begin
            npc_word = RESET_PC[31:2];
        end else if (br_taken) begin
            npc_word = br_target[31:2];
        end else if (redir_valid_q) begin
            npc_word = redir_tgt_q;
        end
        npc = {npc_word, 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            redir_valid_q <= 1'b0;
            redir_tgt_q   <= 30'h0;
            ibuf_q        <= 32'h0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_tgt_q   <= redir_tgt_d;
            ibuf_q        <= ibuf_d;
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (f_valid && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (stall && (state_q != BOOT) && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_fetch = 32'h0;
    assign perf_stall = 32'h0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus a randomized run
// checked against a transaction-level fetch/branch model.
module tb_pc_seq;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef PC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic        pc_en;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] junk = 32'h0BAD_F00D;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_seq #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_en      (pc_en),
        .npc        (npc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .f_valid    (f_valid),
        .f_instr    (f_instr),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // External PC register and instruction memory surrounding the sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else if (pc_en) pc <= npc;
    end

    always_ff @(posedge clk) junk <= $urandom;

    assign imem_rdata = imem_req ? mem_fn(pc) : junk;

    task automatic do_reset();
        reset = 1'b0; imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [31:0] a);
        int n = 0;
        imem_ack = 1'b1; stall = 1'b0; br_taken = 1'b0;
        while (imem_addr !== a && n < 200) begin
            @(posedge clk); #1; n++;
        end
        n_checks++; if (imem_addr !== a) begin n_fail++; $display("FAIL run_to addr=%h required %h", imem_addr, a); end
    endtask

    task automatic test_reset();
        logic [31:0] exp_npc;
        @(posedge clk); #3;
        reset = 1'b0; imem_ack = 1'b1; stall = 1'b0; br_taken = 1'b0;
        #1;
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en got=%b exp=0", pc_en); end
        n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL rst_f_valid got=%b exp=0", f_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
        n_checks++; if (f_instr !== 32'h0) begin n_fail++; $display("FAIL rst_f_instr got=%h exp=0", f_instr); end
        n_checks++; if (perf_fetch !== 32'h0 || perf_stall !== 32'h0) begin n_fail++; $display("FAIL rst_perf got=%h/%h exp=0", perf_fetch, perf_stall); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (npc !== RESET_PC) begin n_fail++; $display("FAIL boot_npc got=%h exp=%h", npc, RESET_PC); end
        n_checks++; if (imem_req !== 1'b0 || f_valid !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL boot_outputs got=%b%b%b exp=000", imem_req, f_valid, pc_en); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            exp_npc = RESET_PC + 32'd4 * (i + 1);
            @(negedge clk);
            n_checks++; if (f_valid !== 1'b1) begin n_fail++; $display("FAIL seq_f_valid[%0d] got=%b exp=1", i, f_valid); end
            n_checks++; if (npc !== exp_npc) begin n_fail++; $display("FAIL seq_npc[%0d] got=%h exp=%h", i, npc, exp_npc); end
            n_checks++; if (f_instr !== mem_fn(exp_npc - 32'd4)) begin n_fail++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, f_instr, mem_fn(exp_npc - 32'd4)); end
            $display("reset_seq: cycle %0d npc=%h f_valid=%b", i, npc, f_valid);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_ack();
        do_reset();
        run_to(32'h0000_3008);
        br_taken = 1'b1; br_target = 32'h0000_3100;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b1 || f_instr !== mem_fn(32'h3008)) begin n_fail++; $display("FAIL br_ack_delay_slot got=%b/%h exp=1/%h", f_valid, f_instr, mem_fn(32'h3008)); end
        n_checks++; if (npc !== 32'h0000_3100) begin n_fail++; $display("FAIL br_ack_npc got=%h exp=00003100", npc); end
        @(posedge clk); #1 br_taken = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'h0000_3100 || npc !== 32'h0000_3104) begin n_fail++; $display("FAIL br_ack_after got=%h/%h exp=00003100/00003104", imem_addr, npc); end
        $display("branch_ack: addr=%h npc=%h", imem_addr, npc);
        @(posedge clk); #1;
    endtask

    task automatic test_branch_wait();
        do_reset();
        run_to(32'h0000_3010);
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3200;
        @(negedge clk);
        n_checks++; if (pc_en !== 1'b0 || f_valid !== 1'b0) begin n_fail++; $display("FAIL br_wait_idle got=%b/%b exp=0/0", pc_en, f_valid); end
        @(posedge clk); #1 br_taken = 1'b0;
        @(negedge clk);
        n_checks++; if (npc !== 32'h0000_3200 || pc_en !== 1'b0) begin n_fail++; $display("FAIL br_wait_pending got=%h/%b exp=00003200/0", npc, pc_en); end
        @(posedge clk); #1 imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b1 || f_instr !== mem_fn(32'h3010)) begin n_fail++; $display("FAIL br_wait_deliver got=%b/%h exp=1/%h", f_valid, f_instr, mem_fn(32'h3010)); end
        n_checks++; if (npc !== 32'h0000_3200) begin n_fail++; $display("FAIL br_wait_npc got=%h exp=00003200", npc); end
        $display("branch_wait: delivered %h npc=%h", f_instr, npc);
        @(posedge clk); #1;
        // Second redirect overwrites the first while waiting for memory.
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3400;
        @(posedge clk); #1 br_target = 32'h0000_3502;
        @(posedge clk); #1 br_taken = 1'b0; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (f_instr !== mem_fn(32'h3200) || npc !== 32'h0000_3500) begin n_fail++; $display("FAIL br_overwrite got=%h/%h exp=%h/00003500", f_instr, npc, mem_fn(32'h3200)); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        do_reset();
        run_to(32'h0000_3020);
        stall = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || pc_en !== 1'b0 || f_valid !== 1'b0) begin n_fail++; $display("FAIL stall_first got=%b%b%b exp=100", imem_req, pc_en, f_valid); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0 || f_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b%b%b exp=000", i, imem_req, pc_en, f_valid); end
        end
        @(posedge clk); #1 stall = 1'b0;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b1 || f_instr !== mem_fn(32'h3020)) begin n_fail++; $display("FAIL stall_release got=%b/%h exp=1/%h", f_valid, f_instr, mem_fn(32'h3020)); end
        n_checks++; if (pc_en !== 1'b1 || npc !== 32'h0000_3024 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_release_pc got=%b/%h/%b exp=1/00003024/0", pc_en, npc, imem_req); end
        n_checks++; if (perf_stall !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall, PERF ? 3 : 0); end
        n_checks++; if (perf_fetch !== (PERF ? 32'd8 : 32'd0)) begin n_fail++; $display("FAIL perf_fetch got=%0d exp=%0d", perf_fetch, PERF ? 8 : 0); end
        $display("stall: released instr=%h perf_stall=%0d perf_fetch=%0d", f_instr, perf_stall, perf_fetch);
        @(posedge clk); #1;
        n_checks++; if (imem_addr !== 32'h0000_3024 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_resume got=%h/%b exp=00003024/1", imem_addr, imem_req); end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++; if (npc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align got=%h exp=fffffffc", npc); end
        @(posedge clk); #1 br_taken = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC || npc !== 32'h0) begin n_fail++; $display("FAIL wrap_npc got=%h/%h exp=fffffffc/00000000", imem_addr, npc); end
        n_checks++; if (f_instr !== mem_fn(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_instr got=%h exp=%h", f_instr, mem_fn(32'hFFFF_FFFC)); end
        $display("wrap: addr=%h npc=%h", imem_addr, npc);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_hold();
        do_reset();
        run_to(32'h0000_3008);
        stall = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        #1;
        n_checks++; if (pc_en !== 1'b0 || f_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_rst_ctrl got=%b%b%b exp=000", pc_en, f_valid, imem_req); end
        n_checks++; if (f_instr !== 32'h0 || npc !== RESET_PC) begin n_fail++; $display("FAIL hold_rst_data got=%h/%h exp=0/%h", f_instr, npc, RESET_PC); end
        n_checks++; if (perf_fetch !== 32'h0 || perf_stall !== 32'h0) begin n_fail++; $display("FAIL hold_rst_perf got=%h/%h exp=0", perf_fetch, perf_stall); end
        stall = 1'b0; imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL hold_rst_boot got=%b exp=0", f_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b1 || imem_addr !== RESET_PC || f_instr !== mem_fn(RESET_PC)) begin n_fail++; $display("FAIL hold_rst_restart got=%b/%h/%h exp=1/%h/%h", f_valid, imem_addr, f_instr, RESET_PC, mem_fn(RESET_PC)); end
        $display("reset_in_hold: restart addr=%h instr=%h", imem_addr, f_instr);
        @(posedge clk); #1;
    endtask

    // Model: one fetched word may wait for delivery; the newest redirect seen
    // since the previous delivery (inclusive of the delivering cycle) picks the next address.
    task automatic test_random();
        logic [31:0] exp_addr, tgt, nxt;
        logic        avail, pend, got, deliver;
        int          nf, ns;
        do_reset();
        exp_addr = RESET_PC; avail = 1'b0; pend = 1'b0; tgt = 32'h0; nf = 0; ns = 0;
        for (int c = 0; c < 400; c++) begin
            imem_ack  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            br_taken  = ($urandom_range(0, 7) == 0);
            br_target = $urandom;
            @(negedge clk);
            got     = avail || imem_ack;
            deliver = got && !stall;
            if (br_taken) begin pend = 1'b1; tgt = {br_target[31:2], 2'b00}; end
            n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, exp_addr); end
            n_checks++; if (imem_req !== !avail) begin n_fail++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, !avail); end
            n_checks++; if (f_valid !== deliver || pc_en !== deliver) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b/%b exp=%b", c, f_valid, pc_en, deliver); end
            n_checks++; if (perf_fetch !== (PERF ? nf : 0) || perf_stall !== (PERF ? ns : 0)) begin n_fail++; $display("FAIL rnd_perf c=%0d got=%0d/%0d exp=%0d/%0d", c, perf_fetch, perf_stall, PERF ? nf : 0, PERF ? ns : 0); end
            if (deliver) begin
                nxt = pend ? tgt : exp_addr + 32'd4;
                n_checks++; if (f_instr !== mem_fn(exp_addr)) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, f_instr, mem_fn(exp_addr)); end
                n_checks++; if (npc !== nxt) begin n_fail++; $display("FAIL rnd_npc c=%0d got=%h exp=%h", c, npc, nxt); end
                $display("random: c=%0d delivered addr=%h instr=%h npc=%h", c, exp_addr, f_instr, npc);
                exp_addr = nxt; pend = 1'b0; avail = 1'b0; nf++;
            end else begin
                avail = got;
            end
            if (stall) ns++;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch_ack();
        test_branch_wait();
        test_stall();
        test_wrap();
        test_reset_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
